// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared MDU operation encodings, FSM state encodings and a
// small classification helper used by the multiply/divide controller.
package mdu_ctrl_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8
   } md_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_e;

   // True for the four operations that occupy the unit for several cycles.
   function automatic logic is_mul_div(input logic [3:0] op);
      logic res;
      case (op)
         MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res = 1'b1;
         default:                            res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: purely combinational arithmetic for the MDU. Produces the
// {HI, LO} pair for mult/multu (64-bit product) and div/divu
// (HI = remainder, LO = quotient). Signed division truncates toward zero
// and the remainder follows the dividend's sign. A zero divisor yields
// LO = all ones and HI = dividend, avoiding any X from the divide operator.
module mdu_calc
   import mdu_ctrl_pkg::*;
(
   input  logic [3:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);

   logic        signed_op_s;
   logic [63:0] a_ext_s;
   logic [63:0] b_ext_s;
   logic [63:0] prod_s;
   logic [31:0] a_mag_s;
   logic [31:0] b_mag_s;
   logic [31:0] divisor_s;
   logic [31:0] q_mag_s;
   logic [31:0] r_mag_s;
   logic [31:0] quot_s;
   logic [31:0] rem_s;

   assign signed_op_s = (md_op == MD_MULT) || (md_op == MD_DIV);

   // Sign- or zero-extend operands and form the 64-bit product.
   always_comb begin
      a_ext_s = signed_op_s ? {{32{a[31]}}, a} : {32'd0, a};
      b_ext_s = signed_op_s ? {{32{b[31]}}, b} : {32'd0, b};
      prod_s  = a_ext_s * b_ext_s;
   end

   // Magnitude divide, then restore signs; zero divisor handled explicitly.
   always_comb begin
      a_mag_s   = (signed_op_s && a[31]) ? (32'd0 - a) : a;
      b_mag_s   = (signed_op_s && b[31]) ? (32'd0 - b) : b;
      divisor_s = (b == 32'd0) ? 32'd1 : b_mag_s;
      q_mag_s   = a_mag_s / divisor_s;
      r_mag_s   = a_mag_s % divisor_s;
      if (b == 32'd0) begin
         quot_s = 32'hFFFF_FFFF;
         rem_s  = a;
      end else begin
         quot_s = (signed_op_s && (a[31] ^ b[31])) ? (32'd0 - q_mag_s) : q_mag_s;
         rem_s  = (signed_op_s && a[31]) ? (32'd0 - r_mag_s) : r_mag_s;
      end
   end

   // Select the result pair for the requested operation.
   always_comb begin
      case (md_op)
         MD_MULT, MD_MULTU: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         MD_DIV, MD_DIVU: begin
            res_hi = rem_s;
            res_lo = quot_s;
         end
         default: begin
            res_hi = 32'd0;
            res_lo = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller. Latches the arithmetic result
// at issue, counts out a fixed latency while busy, then commits to HI/LO.
// Raises stall_md so a D-stage MDU instruction cannot overtake an
// operation in flight.
// Optional feature macro: MDU_DIVZERO_GUARD_EN -- when defined, a divide by
// zero still runs its full busy period but leaves HI/LO untouched.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        D_md,
   output logic        busy,
   output logic        stall_md,
   output logic [31:0] md_out,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   state_e             state_r;
   state_e             state_nxt_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [CNT_W-1:0]   cnt_nxt_s;
   logic [31:0]        tmp_hi_r;
   logic [31:0]        tmp_lo_r;
   logic [31:0]        tmp_hi_nxt_s;
   logic [31:0]        tmp_lo_nxt_s;
   logic [31:0]        hi_r;
   logic [31:0]        lo_r;
   logic [31:0]        hi_nxt_s;
   logic [31:0]        lo_nxt_s;
   logic [31:0]        calc_hi_s;
   logic [31:0]        calc_lo_s;
   logic               start_mul_div_s;
`ifdef MDU_DIVZERO_GUARD_EN
   logic               keep_r;
   logic               keep_nxt_s;
`endif

   mdu_calc u_calc (
      .md_op  (md_op),
      .a      (A),
      .b      (B),
      .res_hi (calc_hi_s),
      .res_lo (calc_lo_s)
   );

   assign start_mul_div_s = start & is_mul_div(md_op);

   // Next-state, counter, result staging and HI/LO update logic.
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r;
      tmp_hi_nxt_s = tmp_hi_r;
      tmp_lo_nxt_s = tmp_lo_r;
      hi_nxt_s     = hi_r;
      lo_nxt_s     = lo_r;
`ifdef MDU_DIVZERO_GUARD_EN
      keep_nxt_s   = keep_r;
`endif
      case (state_r)
         S_IDLE: begin
            if (start) begin
               case (md_op)
                  MD_MULT, MD_MULTU: begin
                     tmp_hi_nxt_s = calc_hi_s;
                     tmp_lo_nxt_s = calc_lo_s;
                     cnt_nxt_s    = CNT_W'(MULT_CYCLES);
                     state_nxt_s  = S_BUSY;
`ifdef MDU_DIVZERO_GUARD_EN
                     keep_nxt_s   = 1'b0;
`endif
                  end
                  MD_DIV, MD_DIVU: begin
                     tmp_hi_nxt_s = calc_hi_s;
                     tmp_lo_nxt_s = calc_lo_s;
                     cnt_nxt_s    = CNT_W'(DIV_CYCLES);
                     state_nxt_s  = S_BUSY;
`ifdef MDU_DIVZERO_GUARD_EN
                     keep_nxt_s   = (B == 32'd0);
`endif
                  end
                  MD_MTHI: hi_nxt_s = A;
                  MD_MTLO: lo_nxt_s = A;
                  default: begin
                  end
               endcase
            end else begin
            end
         end
         S_BUSY: begin
            // start is ignored here: the stall keeps new MDU ops out of E.
            if (cnt_r == CNT_W'(1)) begin
               state_nxt_s = S_IDLE;
               cnt_nxt_s   = {CNT_W{1'b0}};
`ifdef MDU_DIVZERO_GUARD_EN
               if (!keep_r) begin
                  hi_nxt_s = tmp_hi_r;
                  lo_nxt_s = tmp_lo_r;
               end else begin
               end
`else
               hi_nxt_s = tmp_hi_r;
               lo_nxt_s = tmp_lo_r;
`endif
            end else begin
               cnt_nxt_s = cnt_r - CNT_W'(1);
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State register; synchronous reset discards any in-flight result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= S_IDLE;
         cnt_r    <= {CNT_W{1'b0}};
         tmp_hi_r <= 32'd0;
         tmp_lo_r <= 32'd0;
         hi_r     <= 32'd0;
         lo_r     <= 32'd0;
`ifdef MDU_DIVZERO_GUARD_EN
         keep_r   <= 1'b0;
`endif
      end else begin
         state_r  <= state_nxt_s;
         cnt_r    <= cnt_nxt_s;
         tmp_hi_r <= tmp_hi_nxt_s;
         tmp_lo_r <= tmp_lo_nxt_s;
         hi_r     <= hi_nxt_s;
         lo_r     <= lo_nxt_s;
`ifdef MDU_DIVZERO_GUARD_EN
         keep_r   <= keep_nxt_s;
`endif
      end
   end

   // Read-port mux for mfhi/mflo.
   always_comb begin
      case (md_op)
         MD_MFHI: md_out = hi_r;
         MD_MFLO: md_out = lo_r;
         default: md_out = 32'd0;
      endcase
   end

   assign busy     = (state_r == S_BUSY);
   assign stall_md = D_md & (busy | start_mul_div_s);
   assign HI       = hi_r;
   assign LO       = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl (default latencies).
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        D_md;
   logic        busy;
   logic        stall_md;
   logic [31:0] md_out;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_checks = 0;
   int n_fails  = 0;

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .md_op    (md_op),
      .A        (A),
      .B        (B),
      .D_md     (D_md),
      .busy     (busy),
      .stall_md (stall_md),
      .md_out   (md_out),
      .HI       (HI),
      .LO       (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one cycle; stall_md in the issue cycle is checked first.
   task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic exp_stall;
      md_op = op; A = a; B = b; start = 1'b1;
      exp_stall = D_md & (op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU);
      #1;
      check_eq({tag, "_issue_stall"}, {31'd0, stall_md}, {31'd0, exp_stall});
      step();
      start = 1'b0; md_op = MD_NONE;
   endtask

   // Count busy cycles (bounded), checking stall each cycle; optionally
   // pulse an mthi while busy, which must be ignored.
   task automatic wait_commit(input string tag, input int exp_cycles, input logic inject);
      int n;
      n = 0;
      while (busy && n < 40) begin
         check_eq({tag, "_busy_stall"}, {31'd0, stall_md}, 32'd1);
         if (inject && n == 2) begin
            start = 1'b1; md_op = MD_MTHI; A = 32'h0000_DEAD;
         end else begin
            start = 1'b0; md_op = MD_NONE;
         end
         n++;
         step();
      end
      start = 1'b0; md_op = MD_NONE;
      check_eq({tag, "_busy_cycles"}, n, exp_cycles);
      check_eq({tag, "_post_stall"}, {31'd0, stall_md}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; md_op = MD_NONE; A = 32'd0; B = 32'd0; D_md = 1'b0;
      step(); step();
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_hi", HI, 32'd0);
      check_eq("rst_lo", LO, 32'd0);
      check_eq("rst_md_out", md_out, 32'd0);
      reset = 1'b0;
      D_md = 1'b1;
      step();

      // mult -3 * 5 = -15
      issue("mult", MD_MULT, 32'hFFFF_FFFD, 32'd5);
      check_eq("mult_busy_t1", {31'd0, busy}, 32'd1);
      wait_commit("mult", 5, 1'b0);
      check_eq("mult_hi", HI, 32'hFFFF_FFFF);
      check_eq("mult_lo", LO, 32'hFFFF_FFF1);

      // multu 0xFFFFFFFF * 2 = 0x1_FFFF_FFFE
      issue("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2);
      wait_commit("multu", 5, 1'b0);
      check_eq("multu_hi", HI, 32'h0000_0001);
      check_eq("multu_lo", LO, 32'hFFFF_FFFE);

      // divu 100 / 7 = 14 r 2
      issue("divu", MD_DIVU, 32'd100, 32'd7);
      check_eq("divu_hold_hi", HI, 32'h0000_0001);
      wait_commit("divu", 10, 1'b0);
      check_eq("divu_lo", LO, 32'd14);
      check_eq("divu_hi", HI, 32'd2);

      // div -7 / 2 = -3 r -1, with an mthi pulse while busy that must be ignored
      issue("div", MD_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_commit("div", 10, 1'b1);
      check_eq("div_lo", LO, 32'hFFFF_FFFD);
      check_eq("div_hi", HI, 32'hFFFF_FFFF);

      // mthi / mtlo visible next cycle, no stall
      issue("mthi", MD_MTHI, 32'h0000_1234, 32'd0);
      check_eq("mthi_hi", HI, 32'h0000_1234);
      check_eq("mthi_busy", {31'd0, busy}, 32'd0);
      check_eq("mthi_lo_kept", LO, 32'hFFFF_FFFD);
      issue("mtlo", MD_MTLO, 32'h0000_5678, 32'd0);
      check_eq("mtlo_lo", LO, 32'h0000_5678);

      // mflo / mfhi combinational read
      md_op = MD_MFLO; #1;
      check_eq("mflo_out", md_out, 32'h0000_5678);
      md_op = MD_MFHI; #1;
      check_eq("mfhi_out", md_out, 32'h0000_1234);
      md_op = MD_NONE; #1;
      check_eq("none_out", md_out, 32'd0);
      step();

      // unknown op: no effect
      issue("unk", 4'hF, 32'hCAFE_BABE, 32'd3);
      check_eq("unk_busy", {31'd0, busy}, 32'd0);
      check_eq("unk_hi", HI, 32'h0000_1234);
      check_eq("unk_lo", LO, 32'h0000_5678);

      // divide by zero
      issue("div0", MD_DIV, 32'd9, 32'd0);
      wait_commit("div0", 10, 1'b0);
`ifdef MDU_DIVZERO_GUARD_EN
      check_eq("div0_hi", HI, 32'h0000_1234);
      check_eq("div0_lo", LO, 32'h0000_5678);
`else
      check_eq("div0_hi", HI, 32'd9);
      check_eq("div0_lo", LO, 32'hFFFF_FFFF);
`endif

      // reset on the 3rd busy cycle of a div
      issue("rdiv", MD_DIV, 32'd50, 32'd3);
      step(); step();
      check_eq("rdiv_busy3", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("rdiv_busy", {31'd0, busy}, 32'd0);
      check_eq("rdiv_hi", HI, 32'd0);
      check_eq("rdiv_lo", LO, 32'd0);
      repeat (15) step();
      check_eq("rdiv_late_busy", {31'd0, busy}, 32'd0);
      check_eq("rdiv_late_hi", HI, 32'd0);
      check_eq("rdiv_late_lo", LO, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
